// File: rtl/pl_stage_msg_decode_pkg.sv
// Shared constants and types for the NewHope512 encode/add/subtract/decode stages.
// No logic of its own.
// No flow control; types only.
package pl_stage_msg_decode_pkg;

    localparam int unsigned N           = 512;
    localparam int unsigned MSG_BYTES   = 32;
    localparam int unsigned COEF_W      = 16;
    localparam int unsigned ADDR_W      = 9;
    localparam int unsigned BYTE_ADDR_W = 5;

    localparam logic [COEF_W-1:0] Q      = 16'd12289;
    // Centre of the flipabs fold and the 0/1 decision point of the summed distance.
    localparam logic [13:0]       HALF_Q = 14'd6144;
    localparam logic [13:0]       THRESH = 14'd6144;

    typedef logic [COEF_W-1:0]      coef_t;
    typedef logic [ADDR_W-1:0]      caddr_t;
    typedef logic [BYTE_ADDR_W-1:0] baddr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    // A message bit is 1 when both coefficients sit close to Q/2.
    function automatic logic decide_bit(input logic [12:0] fa, input logic [12:0] fb);
        logic [13:0] sum;
        sum = {1'b0, fa} + {1'b0, fb};
        return (sum < THRESH);
    endfunction

endpackage

// File: rtl/pl_stage_msg_decode_if.sv
// Coefficient write stream in, message byte write stream out, plus stage control.
// No latency; wiring only.
// Plain write strobes, no backpressure in either direction.
interface pl_stage_msg_decode_if;
    import pl_stage_msg_decode_pkg::*;

    logic       en;
    logic       start_stage;
    logic       done_stage;
    logic       we_in;
    caddr_t     addr_in;
    coef_t      din;
    logic       we_m;
    baddr_t     addr_m;
    logic [7:0] dout_m;

    modport master (
        output en, start_stage, we_in, addr_in, din,
        input  done_stage, we_m, addr_m, dout_m
    );

    modport slave (
        input  en, start_stage, we_in, addr_in, din,
        output done_stage, we_m, addr_m, dout_m
    );

endinterface

// File: rtl/pl_stage_msg_decode_coeff_flipabs.sv
// Conditional reduce into [0,Q) then distance from Q/2: |x' - HALF_Q|.
// Purely combinational, zero latency.
// No flow control; valid for inputs in [0, 2Q).
module pl_stage_msg_decode_coeff_flipabs
    import pl_stage_msg_decode_pkg::*;
(
    input  coef_t       x,
    output logic [12:0] y
);

    logic [13:0] xr;

    // Single subtract of Q, then fold around HALF_Q.
    always_comb begin
        xr = (x >= Q) ? 14'(x - Q) : 14'(x);
        y  = (xr >= HALF_Q) ? 13'(xr - HALF_Q) : 13'(HALF_Q - xr);
    end

endmodule

// File: rtl/pl_stage_msg_decode.sv
// Buffers one 512-coefficient polynomial and decodes the 256-bit message (poly_tomsg).
// Byte j written 18+16j cycles after start_stage, done_stage 515 cycles after start.
// en low freezes the whole decode pipeline; coefficient writes ignore en and are dropped while BUSY.
module pl_stage_msg_decode
    import pl_stage_msg_decode_pkg::*;
(
    input logic                  clk,
    input logic                  rst,
    pl_stage_msg_decode_if.slave bus
);

    coef_t       mem [0:N-1];
    coef_t       rdata;
    coef_t       a_reg;
    state_t      state;
    logic [7:0]  bit_idx;
    logic        phase;
    logic        issue_done;
    logic        p1_vld;
    logic        p1_phase;
    logic [7:0]  res_idx;
    logic [6:0]  shreg;
    logic        issuing;
    caddr_t      rd_addr;
    logic [12:0] fa;
    logic [12:0] fb;
    logic        bit_val;
    logic [7:0]  byte_next;

    // Phase 0 reads coefficient i, phase 1 reads its partner i+256.
    assign issuing   = (state == ST_BUSY) && !issue_done;
    assign rd_addr   = {phase, bit_idx};
    assign bit_val   = decide_bit(fa, fb);
    assign byte_next = {bit_val, shreg};

    pl_stage_msg_decode_coeff_flipabs u_fa (.x(a_reg), .y(fa));
    pl_stage_msg_decode_coeff_flipabs u_fb (.x(rdata), .y(fb));

    // Buffer RAM: writes locked out while decoding, read data holds when stalled.
    always_ff @(posedge clk) begin
        if (bus.we_in && (state != ST_BUSY)) begin
            mem[bus.addr_in] <= bus.din;
        end
        if (bus.en && issuing) begin
            rdata <= mem[rd_addr];
        end
    end

    // Control FSM, read sequencing, bit resolve and byte packing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            bit_idx        <= '0;
            phase          <= 1'b0;
            issue_done     <= 1'b0;
            p1_vld         <= 1'b0;
            p1_phase       <= 1'b0;
            res_idx        <= '0;
            shreg          <= '0;
            a_reg          <= '0;
            bus.done_stage <= 1'b0;
            bus.we_m       <= 1'b0;
            bus.addr_m     <= '0;
            bus.dout_m     <= '0;
        end else begin
            // Strobes are single-cycle even if en drops right after them.
            bus.we_m       <= 1'b0;
            bus.done_stage <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start_stage) begin
                        state      <= ST_BUSY;
                        bit_idx    <= '0;
                        phase      <= 1'b0;
                        issue_done <= 1'b0;
                        p1_vld     <= 1'b0;
                        res_idx    <= '0;
                    end
                end
                ST_BUSY: begin
                    if (bus.en) begin
                        p1_vld   <= issuing;
                        p1_phase <= phase;
                        if (issuing) begin
                            phase <= ~phase;
                            if (phase) begin
                                bit_idx <= bit_idx + 8'd1;
                                if (bit_idx == 8'd255) begin
                                    issue_done <= 1'b1;
                                end
                            end
                        end
                        // First coefficient of the pair waits here for its partner.
                        if (p1_vld && !p1_phase) begin
                            a_reg <= rdata;
                        end
                        if (p1_vld && p1_phase) begin
                            shreg   <= {bit_val, shreg[6:1]};
                            res_idx <= res_idx + 8'd1;
                            if (res_idx[2:0] == 3'd7) begin
                                bus.we_m   <= 1'b1;
                                bus.addr_m <= res_idx[7:3];
                                bus.dout_m <= byte_next;
                            end
                            if (res_idx == 8'd255) begin
                                state <= ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.en) begin
                        bus.done_stage <= 1'b1;
                        state          <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pl_stage_msg_decode.sv
// Directed bench for pl_stage_msg_decode with a queue-based scoreboard.
// Expected writes carry their cycle offset from start_stage.
// Monitor samples on the falling edge; stimulus drives 1 time unit after the rising edge.
module tb_pl_stage_msg_decode;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pl_stage_msg_decode_if bus();

    pl_stage_msg_decode dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int addr;
        int data;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    exp_t e;
    int   tests     = 0;
    int   fails     = 0;
    int   cyc       = 0;
    int   t0        = 0;
    int   we_seen   = 0;
    int   done_seen = 0;
    int   we0;
    int   dn0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every write and done pulse must match the head of its queue.
    always @(negedge clk) begin
        if (bus.we_m === 1'b1) begin
            we_seen++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_we_m: got addr=%0d data=%02h at cycle %0d, required no write",
                         bus.addr_m, bus.dout_m, cyc - t0);
            end else begin
                e = exp_q.pop_front();
                if (bus.addr_m !== 5'(e.addr) || bus.dout_m !== 8'(e.data) || (cyc - t0) != e.cyc) begin
                    fails++;
                    $display("FAIL msg_write: got addr=%0d data=%02h cycle=%0d, required addr=%0d data=%02h cycle=%0d",
                             bus.addr_m, bus.dout_m, cyc - t0, e.addr, e.data, e.cyc);
                end
            end
        end
        if (bus.done_stage === 1'b1) begin
            done_seen++;
            tests++;
            if (done_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: got done_stage at cycle %0d, required none", cyc - t0);
            end else if ((cyc - t0) != done_q[0]) begin
                fails++;
                $display("FAIL done_cycle: got cycle %0d, required %0d", cyc - t0, done_q[0]);
                void'(done_q.pop_front());
            end else begin
                void'(done_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // 0: all 6144; 1: zeros with x0=6144, x1=6143, x257=6144; 2: i%3==0 pattern with some 6144+Q.
    function automatic int coef(input int mode, input int idx);
        int k;
        k = idx % 256;
        case (mode)
            0: return 6144;
            1: begin
                if (idx == 0)        return 6144;
                else if (idx == 1)   return 6143;
                else if (idx == 257) return 6144;
                else                 return 0;
            end
            default: begin
                if (k % 3 == 0) return (idx >= 256 && k % 2 == 0) ? 18433 : 6144;
                else            return 0;
            end
        endcase
    endfunction

    // Hand-derived byte values; 3 = all 0xFF except bit 5 of byte 0 cleared.
    function automatic int exp_byte(input int mode, input int j);
        int pat [3];
        pat = '{8'h49, 8'h92, 8'h24};
        case (mode)
            0:       return 8'hFF;
            1:       return (j == 0) ? 8'h02 : 8'h00;
            2:       return pat[j % 3];
            default: return (j == 0) ? 8'hDF : 8'hFF;
        endcase
    endfunction

    task automatic load(input int mode);
        for (int i = 0; i < 512; i++) begin
            bus.we_in   = 1'b1;
            bus.addr_in = 9'(i);
            bus.din     = 16'(coef(mode, i));
            tick(1);
        end
        bus.we_in = 1'b0;
    endtask

    // Stalls are 5 cycles at offsets 100 and 300; a write registered at or after a stall slips by 5.
    task automatic expect_bytes(input int mode, input int nbytes, input int stall);
        exp_t x;
        int   t;
        for (int j = 0; j < nbytes; j++) begin
            t = 18 + 16 * j;
            if (stall != 0) begin
                if (t - 1 >= 100) t += 5;
                if (t - 1 >= 300) t += 5;
            end
            x.addr = j;
            x.data = exp_byte(mode, j);
            x.cyc  = t;
            exp_q.push_back(x);
        end
    endtask

    task automatic start_run;
        bus.start_stage = 1'b1;
        t0 = cyc;
        tick(1);
        bus.start_stage = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int d0;
        bit got;
        d0  = done_seen;
        got = 1'b0;
        for (int n = 0; n < limit && !got; n++) begin
            tick(1);
            if (done_seen != d0) got = 1'b1;
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL done_timeout: no done_stage within %0d cycles, required one", limit);
        end
        tick(2);
        tests++;
        if (exp_q.size() != 0 || done_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d writes and %0d done pulses pending, required 0 and 0",
                     exp_q.size(), done_q.size());
            exp_q.delete();
            done_q.delete();
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.en          = 1'b1;
        bus.start_stage = 1'b0;
        bus.we_in       = 1'b0;
        bus.addr_in     = '0;
        bus.din         = '0;
        tick(3);
        rst = 1'b0;
        tick(1);

        tests++;
        if (bus.done_stage !== 1'b0 || bus.we_m !== 1'b0 || bus.addr_m !== 5'd0 || bus.dout_m !== 8'd0) begin
            fails++;
            $display("FAIL reset_outputs: done=%b we=%b addr=%0d dout=%02h, required all 0",
                     bus.done_stage, bus.we_m, bus.addr_m, bus.dout_m);
        end

        // All coefficients at Q/2: every bit 1, nominal timing.
        load(0);
        expect_bytes(0, 32, 0);
        done_q.push_back(515);
        start_run();
        wait_done(700);

        // Threshold edges: sum 6144 gives 0, sum 1 gives 1.
        load(1);
        expect_bytes(1, 32, 0);
        done_q.push_back(515);
        start_run();
        wait_done(700);

        // Every third bit set, with reduce-by-Q inputs; a second start at cycle 50 is ignored.
        load(2);
        expect_bytes(2, 32, 0);
        done_q.push_back(515);
        start_run();
        tick(49);
        bus.start_stage = 1'b1;
        tick(1);
        bus.start_stage = 1'b0;
        wait_done(700);

        // Same data, en low for 5 cycles at offsets 100 and 300.
        expect_bytes(2, 32, 1);
        done_q.push_back(525);
        start_run();
        tick(99);
        bus.en = 1'b0;
        tick(5);
        bus.en = 1'b1;
        tick(195);
        bus.en = 1'b0;
        tick(5);
        bus.en = 1'b1;
        wait_done(700);

        // Reset at offset 200: only bytes 0..11 may appear.
        expect_bytes(2, 12, 0);
        we0 = we_seen;
        dn0 = done_seen;
        start_run();
        tick(199);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tests++;
        if (bus.we_m !== 1'b0 || bus.addr_m !== 5'd0 || bus.dout_m !== 8'd0) begin
            fails++;
            $display("FAIL midrun_reset_outputs: we=%b addr=%0d dout=%02h, required 0 0 00",
                     bus.we_m, bus.addr_m, bus.dout_m);
        end
        tick(600);
        tests++;
        if ((we_seen - we0) != 12 || (done_seen - dn0) != 0) begin
            fails++;
            $display("FAIL midrun_reset_count: got %0d writes %0d done, required 12 writes 0 done",
                     we_seen - we0, done_seen - dn0);
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL midrun_reset_drain: %0d writes pending, required 0", exp_q.size());
            exp_q.delete();
        end

        // Fresh load after the aborted run.
        load(1);
        expect_bytes(1, 32, 0);
        done_q.push_back(515);
        start_run();
        wait_done(700);

        // Write to addr 5 while BUSY must not disturb the decode.
        load(0);
        expect_bytes(0, 32, 0);
        done_q.push_back(515);
        start_run();
        tick(4);
        bus.we_in   = 1'b1;
        bus.addr_in = 9'd5;
        bus.din     = 16'd0;
        tick(1);
        bus.we_in = 1'b0;
        wait_done(700);

        // Write issued in the same cycle as start_stage is seen by the decode.
        expect_bytes(3, 32, 0);
        done_q.push_back(515);
        bus.we_in   = 1'b1;
        bus.addr_in = 9'd5;
        bus.din     = 16'd0;
        start_run();
        bus.we_in = 1'b0;
        wait_done(700);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
